// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU with a
// single registered result slot that can be drained and refilled in one cycle.
module alu_arbiter #(
    parameter logic [3:0] IDLE_OP = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_zero
);
    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                          state_q, state_d;
    logic                            rr_q, rr_d;
    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]               rsp_c_q, rsp_c_d;
    logic                            rsp_zero_q, rsp_zero_d;

    logic [NUM_REQ-1:0][DATA_W-1:0]  lane_a, lane_b;
    logic [NUM_REQ-1:0][OP_W-1:0]    lane_op;
    logic                            drain, slot_free, gnt_vld, gnt_idx;

    assign lane_a  = req_a;
    assign lane_b  = req_b;
    assign lane_op = req_op;

    // Only the holding requester's rsp_ready can free the slot.
    assign drain     = |(rsp_valid_q & rsp_ready);
    assign slot_free = !rst && (state_q == IDLE || drain);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (slot_free) begin
            case (req_valid)
                2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0; end
                2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1; end
                2'b11:   begin gnt_vld = 1'b1; gnt_idx = rr_q; end
                default: begin gnt_vld = 1'b0; gnt_idx = 1'b0; end
            endcase
        end
    end

    always_comb begin
        req_ready = 2'b00;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = IDLE_OP;
        if (gnt_vld) begin
            req_ready = 2'b01 << gnt_idx;
            alu_a     = lane_a[gnt_idx];
            alu_b     = lane_b[gnt_idx];
            alu_op    = lane_op[gnt_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_zero_d  = rsp_zero_q;
        if (gnt_vld) begin
            // A new transfer overwrites whatever is being drained this cycle.
            state_d     = HOLD;
            rr_d        = ~gnt_idx;
            rsp_valid_d = 2'b01 << gnt_idx;
            rsp_c_d     = alu_c;
            rsp_zero_d  = alu_zero;
        end else if (state_q == HOLD && drain) begin
            state_d     = IDLE;
            rsp_valid_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_c_q     <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter and its single result slot.
module tb_alu_arbiter;
    localparam logic [3:0] OP_PASS = 4'hF;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [31:0] alu_a, alu_b, alu_c, rsp_c;
    logic [3:0]  alu_op;
    logic        alu_zero, rsp_zero;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: is a result held, whose, what value, whose turn.
    bit          m_full;
    int          m_k;
    logic [31:0] m_c;
    bit          m_z;
    int          m_rr;

    alu_arbiter #(.IDLE_OP(OP_PASS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a;
        endcase
    endfunction

    // Environment ALU feeding the DUT.
    always_comb begin
        alu_c    = ref_alu(alu_op, alu_a, alu_b);
        alu_zero = (alu_c == 32'd0);
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        m_full = 0; m_k = 0; m_c = '0; m_z = 0; m_rr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        set_req(0, 32'd9, 32'd4, OP_ADD);
        set_req(1, 32'd6, 32'd2, OP_SUB);
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (rsp_valid !== 2'b00 || rsp_c !== 32'd0 || rsp_zero !== 1'b0) begin
            bad++; $display("FAIL reset_rsp got v=%b c=%0d z=%b exp v=00 c=0 z=0", rsp_valid, rsp_c, rsp_zero);
        end
        total++;
        if (req_ready !== 2'b00 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== OP_PASS) begin
            bad++; $display("FAIL reset_req got rdy=%b a=%0d b=%0d op=%h exp rdy=00 a=0 b=0 op=%h", req_ready, alu_a, alu_b, alu_op, OP_PASS);
        end
        do_reset();
    endtask

    task automatic test_single();
        req_valid = 2'b01; rsp_ready = 2'b01;
        set_req(0, 32'd5, 32'd3, OP_ADD);
        #1;
        total++;
        if (req_ready !== 2'b01 || alu_a !== 32'd5 || alu_op !== OP_ADD) begin
            bad++; $display("FAIL single_grant got rdy=%b a=%0d op=%h exp rdy=01 a=5 op=%h", req_ready, alu_a, alu_op, OP_ADD);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00; #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_c !== 32'd8 || rsp_zero !== 1'b0) begin
            bad++; $display("FAIL single_rsp got v=%b c=%0d z=%b exp v=01 c=8 z=0", rsp_valid, rsp_c, rsp_zero);
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++; $display("FAIL single_drain got v=%b exp v=00", rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [31:0] prev_c;
        logic [1:0]  prev_v;
        prev_c = '0; prev_v = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 32'd10 + i, i, OP_ADD);
            set_req(1, 32'd100 + i, 32'd3, OP_SUB);
            req_valid = (i < 4) ? 2'b11 : 2'b00;
            #1;
            if (i > 0) begin
                total++;
                if (rsp_valid !== prev_v || rsp_c !== prev_c) begin
                    bad++; $display("FAIL contention_rsp[%0d] got v=%b c=%0d exp v=%b c=%0d", i, rsp_valid, rsp_c, prev_v, prev_c);
                end
            end
            if (i < 4) begin
                prev_v = (i % 2 == 0) ? 2'b01 : 2'b10;
                prev_c = (i % 2 == 0) ? 32'd10 + 2 * i : 32'd97 + i;
                total++;
                if (req_ready !== prev_v) begin
                    bad++; $display("FAIL contention_grant[%0d] got rdy=%b exp rdy=%b", i, req_ready, prev_v);
                end
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 2'b10; rsp_ready = 2'b00;
        set_req(1, 32'd7, 32'd7, OP_SUB);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b11;
        set_req(0, 32'd1, 32'd1, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (rsp_valid !== 2'b10 || rsp_c !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== 2'b00) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b c=%0d z=%b rdy=%b exp v=10 c=0 z=1 rdy=00", i, rsp_valid, rsp_c, rsp_zero, req_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        req_valid = 2'b01; rsp_ready = 2'b10;
        set_req(0, 32'd20, 32'd22, OP_ADD);
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL bp_release got rdy=%b exp rdy=01", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01; #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_c !== 32'd42 || rsp_zero !== 1'b0) begin
            bad++; $display("FAIL bp_next got v=%b c=%0d z=%b exp v=01 c=42 z=0", rsp_valid, rsp_c, rsp_zero);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_c;
        exp_c = '0;
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 4) ? 2'b01 : 2'b00;
            set_req(0, 32'h1 << i, 32'h100 << i, OP_OR);
            #1;
            if (i > 0) begin
                total++;
                if (rsp_valid !== 2'b01 || rsp_c !== exp_c) begin
                    bad++; $display("FAIL b2b_rsp[%0d] got v=%b c=%h exp v=01 c=%h", i, rsp_valid, rsp_c, exp_c);
                end
            end
            if (i < 4) begin
                exp_c = (32'h1 << i) | (32'h100 << i);
                total++;
                if (req_ready !== 2'b01) begin
                    bad++; $display("FAIL b2b_grant[%0d] got rdy=%b exp rdy=01", i, req_ready);
                end
            end
            @(posedge clk); @(negedge clk);
        end
        #1;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++; $display("FAIL b2b_drain got v=%b exp v=00", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 32'd30, 32'd12, OP_ADD);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00; #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_c !== 32'd42) begin
            bad++; $display("FAIL rst_pre got v=%b c=%0d exp v=01 c=42", rsp_valid, rsp_c);
        end
        rst = 1'b1; #1;
        total++;
        if (rsp_valid !== 2'b00 || rsp_c !== 32'd0) begin
            bad++; $display("FAIL rst_async got v=%b c=%0d exp v=00 c=0", rsp_valid, rsp_c);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0; rsp_ready = 2'b01;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++; $display("FAIL rst_stale got v=%b exp v=00", rsp_valid);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b01;
        set_req(0, 32'd8, 32'd8, OP_XOR);
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL rst_first_edge got rdy=%b exp rdy=01", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00; #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_c !== 32'd0 || rsp_zero !== 1'b1) begin
            bad++; $display("FAIL rst_first_rsp got v=%b c=%0d z=%b exp v=01 c=0 z=1", rsp_valid, rsp_c, rsp_zero);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_idle();
        req_valid = 2'b00; rsp_ready = 2'b11;
        set_req(0, 32'hDEAD, 32'hBEEF, OP_ADD);
        set_req(1, 32'h1234, 32'h5678, OP_XOR);
        #1;
        total++;
        if (alu_op !== OP_PASS || alu_a !== 32'd0 || alu_b !== 32'd0 || req_ready !== 2'b00) begin
            bad++; $display("FAIL idle got op=%h a=%h b=%h rdy=%b exp op=%h a=0 b=0 rdy=00", alu_op, alu_a, alu_b, req_ready, OP_PASS);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random();
        bit          free;
        int          g;
        logic [1:0]  exp_rdy, exp_v;
        logic [31:0] exp_a, exp_b;
        logic [3:0]  exp_op;
        logic [3:0]  ops [6];
        ops = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_PASS};
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++)
                set_req(i, 32'($urandom_range(0, 7)), 32'($urandom_range(0, 7)), ops[$urandom_range(0, 5)]);
            #1;
            free = !m_full || rsp_ready[m_k];
            g = -1;
            if (free) begin
                if (req_valid == 2'b11) g = m_rr;
                else if (req_valid == 2'b01) g = 0;
                else if (req_valid == 2'b10) g = 1;
            end
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            exp_a   = (g >= 0) ? req_a[32*g +: 32] : 32'd0;
            exp_b   = (g >= 0) ? req_b[32*g +: 32] : 32'd0;
            exp_op  = (g >= 0) ? req_op[4*g +: 4] : OP_PASS;
            exp_v   = m_full ? 2'(1 << m_k) : 2'b00;
            total++;
            if (req_ready !== exp_rdy || alu_a !== exp_a || alu_b !== exp_b || alu_op !== exp_op) begin
                bad++; $display("FAIL rand_grant[%0d] got rdy=%b a=%h b=%h op=%h exp rdy=%b a=%h b=%h op=%h",
                                cyc, req_ready, alu_a, alu_b, alu_op, exp_rdy, exp_a, exp_b, exp_op);
            end
            total++;
            if (rsp_valid !== exp_v || (m_full && (rsp_c !== m_c || rsp_zero !== m_z))) begin
                bad++; $display("FAIL rand_rsp[%0d] got v=%b c=%h z=%b exp v=%b c=%h z=%b",
                                cyc, rsp_valid, rsp_c, rsp_zero, exp_v, m_c, m_z);
            end
            @(posedge clk);
            if (g >= 0) begin
                m_full = 1; m_k = g; m_rr = 1 - g;
                m_c = ref_alu(exp_op, exp_a, exp_b);
                m_z = (m_c == 32'd0);
            end else if (m_full && rsp_ready[m_k]) begin
                m_full = 0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_hold();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter IDLE_OP, default 4'b0000, the opcode driven on alu_op when no request is granted (ALU pass-through of A).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester operation valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester acceptance; a transfer occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-006 req_a  input  64  operand A; bits [32i+31:32i] belong to requester i.
REQ-007 req_b  input  64  operand B, packed as req_a.
REQ-008 req_op  input  8  4-bit ALU opcode; bits [4i+3:4i] belong to requester i.
REQ-009 alu_a  output  32  operand A to the shared ALU.
REQ-010 alu_b  output  32  operand B to the shared ALU.
REQ-011 alu_op  output  4  opcode to the shared ALU.
REQ-012 alu_c  input  32  combinational ALU result.
REQ-013 alu_zero  input  1  combinational ALU zero flag.
REQ-014 rsp_valid  output  2  one-hot (or zero) result valid; bit i marks the result as requester i's.
REQ-015 rsp_ready  input  2  per-requester result acceptance.
REQ-016 rsp_c  output  32  registered result, shared by both requesters.
REQ-017 rsp_zero  output  1  registered zero flag, shared by both requesters.

Function
REQ-018 Two states: IDLE (result register empty) and HOLD (result register full, rsp_valid nonzero).
REQ-019 The result slot is free when the state is IDLE, or when the state is HOLD and rsp_valid[k] & rsp_ready[k] for the holding requester k.
REQ-020 Grant is combinational: if the slot is free, the granted requester g is the only valid requester, or, if both are valid, the one selected by the round-robin pointer rr; no grant if the slot is not free or no request is valid.
REQ-021 req_ready[g] = 1 for the granted requester only; req_ready = 2'b00 otherwise; req_ready never depends on req_valid of the same requester except through grant selection.
REQ-022 While a grant exists, alu_a/alu_b/alu_op carry requester g's operands/opcode; otherwise alu_a = 0, alu_b = 0, alu_op = IDLE_OP.
REQ-023 On a transfer, rsp_c <= alu_c, rsp_zero <= alu_zero, rsp_valid <= one-hot(g), state <= HOLD; result latency is exactly one cycle after acceptance.
REQ-024 In HOLD with rsp_ready[k] = 1 and no new transfer: rsp_valid <= 0, state <= IDLE.
REQ-025 Simultaneous drain and accept in the same cycle: the new result replaces the old; state stays HOLD; full throughput of one operation per cycle.
REQ-026 In HOLD without rsp_ready[k]: rsp_c, rsp_zero and rsp_valid hold their values; req_ready = 2'b00.
REQ-027 rr starts at 0 and, after each transfer, is set to the requester not granted (~g); with one valid requester, it is granted every free cycle regardless of rr.
REQ-028 rsp_ready bits for a requester whose rsp_valid bit is 0 are ignored.
REQ-029 Operands and opcodes of requesters without a grant never reach the ALU outputs.

Reset
REQ-030 While rst is high, asynchronously: state = IDLE, rr = 0, rsp_valid = 2'b00, rsp_c = 0, rsp_zero = 0; req_ready = 2'b00 and ALU outputs at idle values.
REQ-031 Reset asserted mid-operation discards any held result; no rsp_valid pulse is produced for it after rst falls.
REQ-032 The first rising edge after rst deasserts may accept a request.

Verification
REQ-033 Single op: req_valid=01, req_a[31:0]=5, req_b[31:0]=3, op=ALU_ADD, rsp_ready=01 -> req_ready=01 that cycle; next cycle rsp_valid=01, rsp_c=8, rsp_zero=0; the following cycle rsp_valid=00.
REQ-034 Contention: both valid every cycle, rsp_ready=11, rr=0 -> grants alternate 0,1,0,1; rsp_valid sequence 01,10,01,10 with matching results.
REQ-035 Backpressure: requester 1 gets an ALU_SUB with 7,7; rsp_ready=00 for 3 cycles -> rsp_valid=10, rsp_c=0, rsp_zero=1 held stable; req_ready=00 throughout; release -> accept next request the same cycle.
REQ-036 Back-to-back: requester 0 streams 4 ALU_OR ops with rsp_ready=01 held -> 4 results on 4 consecutive cycles, state never returns to IDLE.
REQ-037 Reset mid-HOLD: assert rst while rsp_valid=01 -> rsp_valid=00, rsp_c=0 immediately (before the next clock edge); no stale result after release.
REQ-038 Idle: req_valid=00 -> alu_op=IDLE_OP, alu_a=alu_b=0, req_ready=00.
